layer_mem_arbiter: RTL and testbench

LAYER_MEM_ARBITER -- requirements
Module: layer_mem_arbiter

---
 rtl/layer_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_layer_mem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_mem_arbiter.sv
// Two-port arbiter between the inference engine and the debug host for the layer memory.
// Round-robin on conflict, optional host lock for dump bursts, registered memory strobes.
module layer_mem_arbiter #(
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        e_req_i,
    input  logic        e_we_i,
    input  logic [2:0]  e_sel_i,
    input  logic [11:0] e_addr_i,
    input  logic [19:0] e_wdata_i,
    output logic        e_gnt_o,
    output logic        e_rvalid_o,
    output logic [19:0] e_rdata_o,

    input  logic        h_req_i,
    input  logic        h_we_i,
    input  logic [2:0]  h_sel_i,
    input  logic [11:0] h_addr_i,
    input  logic [19:0] h_wdata_i,
    input  logic        h_lock_i,
    output logic        h_gnt_o,
    output logic        h_rvalid_o,
    output logic [19:0] h_rdata_o,

    output logic        m_cwr_o,
    output logic        m_crd_o,
    output logic [2:0]  m_csel_o,
    output logic [11:0] m_addr_o,
    output logic [19:0] m_wdata_o,
    input  logic [19:0] m_rdata_i,

    output logic        sel_err_o,
    output logic [15:0] conflict_cnt_o
);

    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
    localparam logic [CntW-1:0] LockMax = CntW'(LOCK_MAX);

    typedef enum logic [0:0] {StArb, StHostLock} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            last_host_q, last_host_d;
    logic            e_gnt, h_gnt, lock_hold;

    // Arbitration and lock FSM
    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        e_gnt       = 1'b0;
        h_gnt       = 1'b0;
        lock_hold   = (state_q == StHostLock) && h_req_i && h_lock_i && (lock_cnt_q < LockMax);
        if (lock_hold) begin
            h_gnt      = 1'b1;
            lock_cnt_d = lock_cnt_q + 1'b1;
        end else begin
            if (e_req_i && h_req_i) begin
                e_gnt = last_host_q;
                h_gnt = ~last_host_q;
            end else begin
                e_gnt = e_req_i;
                h_gnt = h_req_i;
            end
            if (h_gnt && h_lock_i) begin
                state_d    = StHostLock;
                lock_cnt_d = CntW'(1);
            end else begin
                state_d    = StArb;
                lock_cnt_d = '0;
            end
        end
        last_host_d = h_gnt ? 1'b1 : (e_gnt ? 1'b0 : last_host_q);
    end

    assign e_gnt_o = e_gnt;
    assign h_gnt_o = h_gnt;

    // Granted command mux
    logic        gnt_any, c_we, sel_ok;
    logic [2:0]  c_sel;
    logic [11:0] c_addr;
    logic [19:0] c_wdata;

    assign gnt_any = e_gnt | h_gnt;
    assign c_we    = h_gnt ? h_we_i    : e_we_i;
    assign c_sel   = h_gnt ? h_sel_i   : e_sel_i;
    assign c_addr  = h_gnt ? h_addr_i  : e_addr_i;
    assign c_wdata = h_gnt ? h_wdata_i : e_wdata_i;
    assign sel_ok  = (c_sel != 3'd0) && (c_sel <= 3'd5);

    logic        m_cwr_q, m_cwr_d, m_crd_q, m_crd_d;
    logic [2:0]  m_csel_q, m_csel_d;
    logic [11:0] m_addr_q, m_addr_d;
    logic [19:0] m_wdata_q, m_wdata_d;
    logic        sel_err_q, sel_err_d;
    logic [15:0] conflict_q, conflict_d;

    always_comb begin
        m_cwr_d    = gnt_any & c_we & sel_ok;
        m_crd_d    = gnt_any & ~c_we & sel_ok;
        m_csel_d   = gnt_any ? c_sel : m_csel_q;
        m_addr_d   = gnt_any ? c_addr : m_addr_q;
        m_wdata_d  = gnt_any ? c_wdata : m_wdata_q;
        sel_err_d  = sel_err_q | (gnt_any & ~sel_ok);
        conflict_d = conflict_q;
        if (e_req_i && h_req_i && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    // Read-return owner pipeline: stage 1 = strobe cycle, stage 2 = data cycle
    logic p1_valid_q, p1_host_q, p1_bad_q;
    logic p2_valid_q, p2_host_q, p2_bad_q;
    logic [19:0] rd_val, e_rdata_q, h_rdata_q;

    assign rd_val     = p2_bad_q ? 20'd0 : m_rdata_i;
    assign e_rvalid_o = p2_valid_q & ~p2_host_q;
    assign h_rvalid_o = p2_valid_q & p2_host_q;
    assign e_rdata_o  = e_rvalid_o ? rd_val : e_rdata_q;
    assign h_rdata_o  = h_rvalid_o ? rd_val : h_rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StArb;
            lock_cnt_q  <= '0;
            last_host_q <= 1'b1;
            m_cwr_q     <= 1'b0;
            m_crd_q     <= 1'b0;
            m_csel_q    <= 3'd0;
            m_addr_q    <= 12'd0;
            m_wdata_q   <= 20'd0;
            sel_err_q   <= 1'b0;
            conflict_q  <= 16'd0;
            p1_valid_q  <= 1'b0;
            p1_host_q   <= 1'b0;
            p1_bad_q    <= 1'b0;
            p2_valid_q  <= 1'b0;
            p2_host_q   <= 1'b0;
            p2_bad_q    <= 1'b0;
            e_rdata_q   <= 20'd0;
            h_rdata_q   <= 20'd0;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            last_host_q <= last_host_d;
            m_cwr_q     <= m_cwr_d;
            m_crd_q     <= m_crd_d;
            m_csel_q    <= m_csel_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            sel_err_q   <= sel_err_d;
            conflict_q  <= conflict_d;
            p1_valid_q  <= gnt_any & ~c_we;
            p1_host_q   <= h_gnt;
            p1_bad_q    <= ~sel_ok;
            p2_valid_q  <= p1_valid_q;
            p2_host_q   <= p1_host_q;
            p2_bad_q    <= p1_bad_q;
            e_rdata_q   <= e_rdata_o;
            h_rdata_q   <= h_rdata_o;
        end
    end

    assign m_cwr_o        = m_cwr_q;
    assign m_crd_o        = m_crd_q;
    assign m_csel_o       = m_csel_q;
    assign m_addr_o       = m_addr_q;
    assign m_wdata_o      = m_wdata_q;
    assign sel_err_o      = sel_err_q;
    assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Bench for layer_mem_arbiter: directed literal checks plus a per-cycle reference model.
module tb_layer_mem_arbiter;

    localparam int LockMax = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_req, e_we, h_req, h_we, h_lock;
    logic [2:0]  e_sel, h_sel;
    logic [11:0] e_addr, h_addr;
    logic [19:0] e_wdata, h_wdata, m_rdata;
    logic        e_gnt, e_rvalid, h_gnt, h_rvalid, m_cwr, m_crd, sel_err;
    logic [19:0] e_rdata, h_rdata, m_wdata;
    logic [2:0]  m_csel;
    logic [11:0] m_addr;
    logic [15:0] conflict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    layer_mem_arbiter #(.LOCK_MAX(LockMax)) dut (
        .clk(clk), .reset(reset),
        .e_req_i(e_req), .e_we_i(e_we), .e_sel_i(e_sel), .e_addr_i(e_addr),
        .e_wdata_i(e_wdata), .e_gnt_o(e_gnt), .e_rvalid_o(e_rvalid), .e_rdata_o(e_rdata),
        .h_req_i(h_req), .h_we_i(h_we), .h_sel_i(h_sel), .h_addr_i(h_addr),
        .h_wdata_i(h_wdata), .h_lock_i(h_lock), .h_gnt_o(h_gnt), .h_rvalid_o(h_rvalid),
        .h_rdata_o(h_rdata), .m_cwr_o(m_cwr), .m_crd_o(m_crd), .m_csel_o(m_csel),
        .m_addr_o(m_addr), .m_wdata_o(m_wdata), .m_rdata_i(m_rdata),
        .sel_err_o(sel_err), .conflict_cnt_o(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {int due; bit host; bit bad;} rd_t;
    rd_t         rq[$];
    int          cyc = 0;
    int          burst = 0;      // consecutive host grants inside a lock burst
    bit          last_host = 1'b1;
    bit          x_cwr, x_crd, x_err;
    logic [2:0]  x_sel;
    logic [11:0] x_addr;
    logic [19:0] x_wdata, x_erd, x_hrd;
    int          x_conf;

    always @(negedge clk) begin
        bit xe, xh, xev, xhv, g, we, ok, cont;
        logic [2:0]  s;
        logic [19:0] d;
        if (reset) begin
            rq.delete();
            burst = 0; last_host = 1'b1;
            x_cwr = 0; x_crd = 0; x_err = 0; x_sel = 0; x_addr = 0; x_wdata = 0;
            x_erd = 0; x_hrd = 0; x_conf = 0;
            chk("rst_m_cwr", m_cwr, 0);     chk("rst_m_crd", m_crd, 0);
            chk("rst_m_csel", m_csel, 0);   chk("rst_m_addr", m_addr, 0);
            chk("rst_m_wdata", m_wdata, 0); chk("rst_e_rvalid", e_rvalid, 0);
            chk("rst_h_rvalid", h_rvalid, 0);
            chk("rst_e_rdata", e_rdata, 0); chk("rst_h_rdata", h_rdata, 0);
            chk("rst_sel_err", sel_err, 0); chk("rst_conflict", conflict_cnt, 0);
        end else begin
            cont = (burst > 0) && h_req && h_lock && (burst < LockMax);
            xh = cont || (h_req && (!e_req || !last_host));
            xe = !xh && e_req;
            xev = 0; xhv = 0; d = 0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                d = rq[0].bad ? 20'd0 : m_rdata;
                if (rq[0].host) begin xhv = 1; x_hrd = d; end
                else begin xev = 1; x_erd = d; end
                void'(rq.pop_front());
            end
            chk("e_gnt", e_gnt, xe);        chk("h_gnt", h_gnt, xh);
            chk("m_cwr", m_cwr, x_cwr);     chk("m_crd", m_crd, x_crd);
            chk("m_csel", m_csel, x_sel);   chk("m_addr", m_addr, x_addr);
            chk("m_wdata", m_wdata, x_wdata);
            chk("e_rvalid", e_rvalid, xev); chk("h_rvalid", h_rvalid, xhv);
            chk("e_rdata", e_rdata, x_erd); chk("h_rdata", h_rdata, x_hrd);
            chk("sel_err", sel_err, x_err); chk("conflict", conflict_cnt, x_conf);
            // advance model to next cycle
            g  = xe || xh;
            we = xh ? h_we : e_we;
            s  = xh ? h_sel : e_sel;
            ok = (s >= 1) && (s <= 5);
            x_cwr = g && we && ok;
            x_crd = g && !we && ok;
            if (g) begin
                x_sel = s; x_addr = xh ? h_addr : e_addr; x_wdata = xh ? h_wdata : e_wdata;
                if (!ok) x_err = 1;
                if (!we) rq.push_back('{due: cyc + 2, host: xh, bad: !ok});
                last_host = xh;
            end
            if (e_req && h_req && x_conf < 16'hFFFF) x_conf++;
            if (xh) burst = cont ? burst + 1 : (h_lock ? 1 : 0);
            else burst = 0;
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(); @(posedge clk); #1; endtask
    task automatic mid();  @(negedge clk); #1; endtask

    function automatic logic [2:0] pick_sel();
        int r = $urandom_range(0, 15);
        if (r < 13) return 3'(1 + r % 5);
        return (r == 13) ? 3'd0 : ((r == 14) ? 3'd6 : 3'd7);
    endfunction

    initial begin
        bit eg, hg;
        reset = 1;
        e_req = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wdata = 0;
        h_req = 0; h_we = 0; h_sel = 0; h_addr = 0; h_wdata = 0; h_lock = 0; m_rdata = 0;
        tick(); tick();
        tick(); reset = 0;

        // first conflict: engine write wins, host read next
        e_req = 1; e_we = 1; e_sel = 1; e_addr = 12'h041; e_wdata = 20'h01310;
        h_req = 1; h_we = 0; h_sel = 3; h_addr = 12'h200;
        mid(); chk("t0_e_gnt", e_gnt, 1); chk("t0_h_gnt", h_gnt, 0);
        tick(); e_sel = 2; e_addr = 12'h055; e_wdata = 20'h12345;
        mid(); chk("t1_h_gnt", h_gnt, 1); chk("t1_m_cwr", m_cwr, 1); chk("t1_m_csel", m_csel, 1);
        chk("t1_m_addr", m_addr, 12'h041); chk("t1_m_wdata", m_wdata, 20'h01310);
        tick(); h_req = 0;
        mid(); chk("t2_e_gnt", e_gnt, 1); chk("t2_conflict", conflict_cnt, 2);
        chk("t2_m_crd", m_crd, 1); chk("t2_m_csel", m_csel, 3);
        tick(); e_req = 0; m_rdata = 20'h0A89E;
        mid(); chk("hrd_valid", h_rvalid, 1); chk("hrd_data", h_rdata, 20'h0A89E);
        chk("hrd_e_rvalid", e_rvalid, 0);
        tick(); m_rdata = 20'h0;
        mid(); chk("hrd_hold", h_rdata, 20'h0A89E); chk("hrd_pulse", h_rvalid, 0);

        // bad select read from engine
        tick(); e_req = 1; e_we = 0; e_sel = 0; e_addr = 12'h007;
        mid(); chk("bad_gnt", e_gnt, 1);
        tick(); e_req = 0;
        mid(); chk("bad_no_crd", m_crd, 0); chk("bad_sel_err", sel_err, 1);
        tick(); m_rdata = 20'hFFFFF;
        mid(); chk("bad_rvalid", e_rvalid, 1); chk("bad_rdata", e_rdata, 0);
        tick(); m_rdata = 0;

        // alternating back-to-back reads
        e_req = 1; e_we = 0; e_sel = 2; e_addr = 12'h010;
        h_req = 1; h_we = 0; h_sel = 4; h_addr = 12'h020;
        mid(); chk("alt0_h_gnt", h_gnt, 1);
        tick(); h_addr = 12'h021;
        mid(); chk("alt1_e_gnt", e_gnt, 1);
        tick(); e_req = 0; m_rdata = 20'h11111;
        mid(); chk("alt2_h_gnt", h_gnt, 1); chk("alt2_h_rvalid", h_rvalid, 1);
        tick(); h_req = 0; m_rdata = 20'h22222;
        mid(); chk("alt3_e_rvalid", e_rvalid, 1); chk("alt3_e_rdata", e_rdata, 20'h22222);
        tick(); m_rdata = 20'h33333;
        mid(); chk("alt4_h_rdata", h_rdata, 20'h33333);
        tick(); m_rdata = 0;

        // host lock burst
        e_req = 1; e_we = 1; e_sel = 5; e_addr = 12'h300; e_wdata = 20'h00ABC;
        tick();
        e_addr = 12'h301;
        h_req = 1; h_we = 1; h_sel = 2; h_addr = 12'h400; h_lock = 1;
        for (int k = 1; k <= 17; k++) begin
            mid();
            if (k <= 16) chk("lock_h_gnt", h_gnt, 1);
            else chk("lock_e_gnt17", e_gnt, 1);
            tick();
            if (k <= 16) h_addr = h_addr + 12'd1;
        end
        e_req = 0; h_lock = 0;
        tick(); h_req = 0;

        // reset right after a read grant
        e_req = 1; e_we = 0; e_sel = 1; e_addr = 12'h005;
        mid(); chk("rr_gnt", e_gnt, 1);
        tick(); e_req = 0; reset = 1;
        mid(); chk("rr_m_crd", m_crd, 0);
        tick(); reset = 0; m_rdata = 20'hABCDE;
        mid(); chk("rr_no_rvalid", e_rvalid, 0); chk("rr_rdata", e_rdata, 0);
        chk("rr_sel_err", sel_err, 0);
        tick(); m_rdata = 0;

        // randomized traffic, fields held until granted
        for (int i = 0; i < 500; i++) begin
            mid(); eg = e_gnt; hg = h_gnt;
            tick();
            if (!e_req || eg) begin
                e_req = ($urandom_range(0, 3) != 0); e_we = 1'($urandom);
                e_sel = pick_sel(); e_addr = 12'($urandom); e_wdata = 20'($urandom);
            end
            if (!h_req || hg) begin
                h_req = ($urandom_range(0, 3) != 0); h_we = 1'($urandom);
                h_sel = pick_sel(); h_addr = 12'($urandom); h_wdata = 20'($urandom);
            end
            h_lock  = ($urandom_range(0, 3) != 0);
            m_rdata = 20'($urandom);
        end
        e_req = 0; h_req = 0; h_lock = 0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
